// File: rtl/axil_if.sv
// AXI4-Lite bus bundle between the request arbiter (master) and a register slave.
interface axil_if #(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ADDR_WIDTH = 2
);
   logic                            awvalid;
   logic                            awready;
   logic [C_AXI_ADDR_WIDTH-1:0]     awaddr;
   logic [2:0]                      awprot;
   logic                            wvalid;
   logic                            wready;
   logic [C_AXI_DATA_WIDTH-1:0]     wdata;
   logic [C_AXI_DATA_WIDTH/8-1:0]   wstrb;
   logic                            bvalid;
   logic                            bready;
   logic [1:0]                      bresp;
   logic                            arvalid;
   logic                            arready;
   logic [C_AXI_ADDR_WIDTH-1:0]     araddr;
   logic [2:0]                      arprot;
   logic                            rvalid;
   logic                            rready;
   logic [C_AXI_DATA_WIDTH-1:0]     rdata;
   logic [1:0]                      rresp;

   modport master (
      output awvalid, awaddr, awprot, input awready,
      output wvalid, wdata, wstrb, input wready,
      input bvalid, bresp, output bready,
      output arvalid, araddr, arprot, input arready,
      input rvalid, rdata, rresp, output rready
   );

   modport slave (
      input awvalid, awaddr, awprot, output awready,
      input wvalid, wdata, wstrb, output wready,
      output bvalid, bresp, input bready,
      input arvalid, araddr, arprot, output arready,
      output rvalid, rdata, rresp, input rready
   );
endinterface

// File: rtl/axil_req_arbiter.sv
// Two-port round-robin arbiter serialising single read/write requests onto one
// AXI4-Lite master port, one transaction at a time, with a response timeout.
module axil_req_arbiter #(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ADDR_WIDTH = 2,
   parameter int TIMEOUT_CYCLES   = 16
) (
   input  logic                            i_clk,
   input  logic                            i_axi_reset_n,
   input  logic                            r0_req,
   input  logic                            r0_we,
   input  logic [C_AXI_ADDR_WIDTH-1:0]     r0_addr,
   input  logic [C_AXI_DATA_WIDTH-1:0]     r0_wdata,
   input  logic [C_AXI_DATA_WIDTH/8-1:0]   r0_wstrb,
   output logic                            r0_ack,
   output logic [C_AXI_DATA_WIDTH-1:0]     r0_rdata,
   output logic [1:0]                      r0_resp,
   input  logic                            r1_req,
   input  logic                            r1_we,
   input  logic [C_AXI_ADDR_WIDTH-1:0]     r1_addr,
   input  logic [C_AXI_DATA_WIDTH-1:0]     r1_wdata,
   input  logic [C_AXI_DATA_WIDTH/8-1:0]   r1_wstrb,
   output logic                            r1_ack,
   output logic [C_AXI_DATA_WIDTH-1:0]     r1_rdata,
   output logic [1:0]                      r1_resp,
   axil_if.master                          m_axi
);
   localparam int DW = C_AXI_DATA_WIDTH;
   localparam int AW = C_AXI_ADDR_WIDTH;
   localparam int SW = C_AXI_DATA_WIDTH / 8;
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_RESP, DONE} state_t;

   state_t          state_r;
   logic            last_grant_r;
   logic            cur_port_r;
   logic [AW-1:0]   addr_r;
   logic [DW-1:0]   wdata_r;
   logic [SW-1:0]   wstrb_r;
   logic [CW-1:0]   cnt_r;
   logic            awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
   logic            ack0_r, ack1_r;
   logic [DW-1:0]   rdata0_r, rdata1_r;
   logic [1:0]      resp0_r, resp1_r;

   logic            grant_s, grant_port_s, sel_we_s;
   logic [AW-1:0]   sel_addr_s;
   logic [DW-1:0]   sel_wdata_s;
   logic [SW-1:0]   sel_wstrb_s;
   logic            timeout_s, aw_ok_s, w_ok_s;
   logic            fin_s, fin_load_s;
   logic [1:0]      fin_resp_s;
   logic [DW-1:0]   fin_rdata_s;

   assign grant_s   = r0_req | r1_req;
   // >= rather than == so a late write-address/data completion can still time out in WR_RESP
   assign timeout_s = (cnt_r >= TO_LAST);
   assign aw_ok_s   = ~awvalid_r | m_axi.awready;
   assign w_ok_s    = ~wvalid_r | m_axi.wready;

   // Round-robin winner selection and payload mux of the winning port
   always_comb begin
      if (r0_req && r1_req) begin
         grant_port_s = ~last_grant_r;
      end else if (r1_req) begin
         grant_port_s = 1'b1;
      end else begin
         grant_port_s = 1'b0;
      end
      if (grant_port_s) begin
         sel_we_s    = r1_we;
         sel_addr_s  = r1_addr;
         sel_wdata_s = r1_wdata;
         sel_wstrb_s = r1_wstrb;
      end else begin
         sel_we_s    = r0_we;
         sel_addr_s  = r0_addr;
         sel_wdata_s = r0_wdata;
         sel_wstrb_s = r0_wstrb;
      end
   end

   // Completion/timeout outcome of the current cycle; completion wins over timeout
   always_comb begin
      fin_s       = 1'b0;
      fin_load_s  = 1'b0;
      fin_resp_s  = 2'b00;
      fin_rdata_s = {DW{1'b0}};
      case (state_r)
         WR: begin
            if (!(aw_ok_s && w_ok_s) && timeout_s) begin
               fin_s      = 1'b1;
               fin_resp_s = 2'b10;
            end else begin
               fin_s      = 1'b0;
            end
         end
         WR_RESP: begin
            if (m_axi.bvalid) begin
               fin_s      = 1'b1;
               fin_resp_s = m_axi.bresp;
            end else if (timeout_s) begin
               fin_s      = 1'b1;
               fin_resp_s = 2'b10;
            end else begin
               fin_s      = 1'b0;
            end
         end
         RD: begin
            if (!m_axi.arready && timeout_s) begin
               fin_s      = 1'b1;
               fin_load_s = 1'b1;
               fin_resp_s = 2'b10;
            end else begin
               fin_s      = 1'b0;
            end
         end
         RD_RESP: begin
            if (m_axi.rvalid) begin
               fin_s       = 1'b1;
               fin_load_s  = 1'b1;
               fin_resp_s  = m_axi.rresp;
               fin_rdata_s = m_axi.rdata;
            end else if (timeout_s) begin
               fin_s      = 1'b1;
               fin_load_s = 1'b1;
               fin_resp_s = 2'b10;
            end else begin
               fin_s      = 1'b0;
            end
         end
         default: begin
            fin_s = 1'b0;
         end
      endcase
   end

   // Sequencer FSM with all bus and requester outputs registered
   always_ff @(posedge i_clk) begin
      if (!i_axi_reset_n) begin
         state_r      <= IDLE;
         last_grant_r <= 1'b1;
         cur_port_r   <= 1'b0;
         addr_r       <= {AW{1'b0}};
         wdata_r      <= {DW{1'b0}};
         wstrb_r      <= {SW{1'b0}};
         cnt_r        <= {CW{1'b0}};
         awvalid_r    <= 1'b0;
         wvalid_r     <= 1'b0;
         bready_r     <= 1'b0;
         arvalid_r    <= 1'b0;
         rready_r     <= 1'b0;
         ack0_r       <= 1'b0;
         ack1_r       <= 1'b0;
         rdata0_r     <= {DW{1'b0}};
         rdata1_r     <= {DW{1'b0}};
         resp0_r      <= 2'b00;
         resp1_r      <= 2'b00;
      end else begin
         ack0_r <= 1'b0;
         ack1_r <= 1'b0;
         case (state_r)
            IDLE: begin
               cnt_r <= {CW{1'b0}};
               if (grant_s) begin
                  last_grant_r <= grant_port_s;
                  cur_port_r   <= grant_port_s;
                  addr_r       <= sel_addr_s;
                  wdata_r      <= sel_wdata_s;
                  wstrb_r      <= sel_wstrb_s;
                  if (sel_we_s) begin
                     awvalid_r <= 1'b1;
                     wvalid_r  <= 1'b1;
                     state_r   <= WR;
                  end else begin
                     arvalid_r <= 1'b1;
                     state_r   <= RD;
                  end
               end
            end
            WR: begin
               cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               if (aw_ok_s && w_ok_s) begin
                  awvalid_r <= 1'b0;
                  wvalid_r  <= 1'b0;
                  bready_r  <= 1'b1;
                  state_r   <= WR_RESP;
               end else if (fin_s) begin
                  awvalid_r <= 1'b0;
                  wvalid_r  <= 1'b0;
                  state_r   <= DONE;
               end else begin
                  if (m_axi.awready) awvalid_r <= 1'b0;
                  if (m_axi.wready)  wvalid_r  <= 1'b0;
               end
            end
            WR_RESP: begin
               cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               if (fin_s) begin
                  bready_r <= 1'b0;
                  state_r  <= DONE;
               end
            end
            RD: begin
               cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               if (m_axi.arready) begin
                  arvalid_r <= 1'b0;
                  rready_r  <= 1'b1;
                  state_r   <= RD_RESP;
               end else if (fin_s) begin
                  arvalid_r <= 1'b0;
                  state_r   <= DONE;
               end
            end
            RD_RESP: begin
               cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               if (fin_s) begin
                  rready_r <= 1'b0;
                  state_r  <= DONE;
               end
            end
            DONE: begin
               cnt_r   <= {CW{1'b0}};
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
         if (fin_s) begin
            if (cur_port_r) begin
               ack1_r  <= 1'b1;
               resp1_r <= fin_resp_s;
               if (fin_load_s) rdata1_r <= fin_rdata_s;
            end else begin
               ack0_r  <= 1'b1;
               resp0_r <= fin_resp_s;
               if (fin_load_s) rdata0_r <= fin_rdata_s;
            end
         end
      end
   end

   assign m_axi.awvalid = awvalid_r;
   assign m_axi.awaddr  = addr_r;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.wvalid  = wvalid_r;
   assign m_axi.wdata   = wdata_r;
   assign m_axi.wstrb   = wstrb_r;
   assign m_axi.bready  = bready_r;
   assign m_axi.arvalid = arvalid_r;
   assign m_axi.araddr  = addr_r;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.rready  = rready_r;

   assign r0_ack   = ack0_r;
   assign r0_rdata = rdata0_r;
   assign r0_resp  = resp0_r;
   assign r1_ack   = ack1_r;
   assign r1_rdata = rdata1_r;
   assign r1_resp  = resp1_r;
endmodule

// File: tb/tb_axil_req_arbiter.sv
// Directed + randomized bench for axil_req_arbiter with a 4x32 register slave
// and a register-array/round-robin reference model.
`timescale 1ns/1ps
module tb_axil_req_arbiter;
   localparam int DW = 32;
   localparam int AW = 2;
   localparam int TO = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req   [0:1];
   logic        we    [0:1];
   logic [1:0]  addr  [0:1];
   logic [31:0] wdata [0:1];
   logic [3:0]  wstrb [0:1];
   logic        ack   [0:1];
   logic [31:0] rdata [0:1];
   logic [1:0]  resp  [0:1];

   axil_if #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW)) bus ();

   axil_req_arbiter #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk(clk), .i_axi_reset_n(rst_n),
      .r0_req(req[0]), .r0_we(we[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]), .r0_wstrb(wstrb[0]),
      .r0_ack(ack[0]), .r0_rdata(rdata[0]), .r0_resp(resp[0]),
      .r1_req(req[1]), .r1_we(we[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]), .r1_wstrb(wstrb[1]),
      .r1_ack(ack[1]), .r1_rdata(rdata[1]), .r1_resp(resp[1]),
      .m_axi(bus)
   );

   // Register slave with programmable AW/W ready delays and optional missing read response
   logic [31:0] sregs [0:3];
   int   aw_delay = 0, w_delay = 0;
   bit   r_never = 1'b0;
   int   aw_cnt, w_cnt;
   bit   aw_got, w_got;
   logic [1:0]  s_addr;
   logic [31:0] s_data;
   logic [3:0]  s_strb;
   int   n_aw_hs = 0, n_w_hs = 0, n_ack0 = 0;

   always @(posedge clk) begin
      if (ack[0]) n_ack0 <= n_ack0 + 1;
      if (!rst_n) begin
         bus.awready <= 1'b0; bus.wready <= 1'b0; bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
         bus.arready <= 1'b0; bus.rvalid <= 1'b0; bus.rdata <= 32'h0; bus.rresp <= 2'b00;
         aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
         for (int i = 0; i < 4; i++) sregs[i] <= 32'h0;
      end else begin
         if (bus.awvalid && bus.awready) begin
            aw_got <= 1'b1; s_addr <= bus.awaddr; aw_cnt <= 0; bus.awready <= 1'b0;
            n_aw_hs <= n_aw_hs + 1;
         end else if (bus.awvalid) begin
            if (aw_cnt >= aw_delay) bus.awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
         end else begin
            bus.awready <= 1'b0;
         end
         if (bus.wvalid && bus.wready) begin
            w_got <= 1'b1; s_data <= bus.wdata; s_strb <= bus.wstrb; w_cnt <= 0; bus.wready <= 1'b0;
            n_w_hs <= n_w_hs + 1;
         end else if (bus.wvalid) begin
            if (w_cnt >= w_delay) bus.wready <= 1'b1; else w_cnt <= w_cnt + 1;
         end else begin
            bus.wready <= 1'b0;
         end
         if (aw_got && w_got && !bus.bvalid) begin
            for (int b = 0; b < 4; b++)
               if (s_strb[b]) sregs[s_addr][8*b +: 8] <= s_data[8*b +: 8];
            bus.bvalid <= 1'b1; bus.bresp <= 2'b00; aw_got <= 1'b0; w_got <= 1'b0;
         end else begin
            bus.bvalid <= 1'b0;
         end
         bus.rvalid <= 1'b0;
         if (bus.arvalid && bus.arready) begin
            bus.arready <= 1'b0;
            if (!r_never) begin
               bus.rvalid <= 1'b1; bus.rdata <= sregs[bus.araddr]; bus.rresp <= 2'b00;
            end
         end else begin
            bus.arready <= bus.arvalid;
         end
      end
   end

   // Reference model: register contents, per-port held read data, last granted port
   logic [31:0] exp_regs  [0:3];
   logic [31:0] exp_rdata [0:1];
   int          last_grant;
   int          vectors = 0, miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) exp_regs[i] = 32'h0;
      exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
      last_grant = 1;
   endtask

   task automatic set_req(input int p, input logic w, input logic [1:0] a,
                          input logic [31:0] d, input logic [3:0] s);
      we[p] = w; addr[p] = a; wdata[p] = d; wstrb[p] = s; req[p] = 1'b1;
   endtask

   task automatic wait_ack(output int p, output int cyc);
      p = -1; cyc = 0;
      for (int i = 0; i < 200 && p < 0; i++) begin
         @(negedge clk); cyc++;
         if (ack[0]) p = 0; else if (ack[1]) p = 1;
      end
      chk("ack_seen", {31'h0, p >= 0}, 32'h1);
   endtask

   // Wait for the next ack, check port order, apply the transaction to the model, compare
   task automatic serve(input int exp_port, input bit drop, output int p);
      int cyc;
      logic [31:0] mask;
      wait_ack(p, cyc);
      if (p >= 0) begin
         chk("grant_port", p, exp_port);
         if (we[p]) begin
            mask = 32'h0;
            for (int b = 0; b < 4; b++) if ((wstrb[p] >> b) & 4'h1) mask = mask | (32'hFF << (8 * b));
            exp_regs[addr[p]] = (exp_regs[addr[p]] & ~mask) | (wdata[p] & mask);
         end else begin
            exp_rdata[p] = exp_regs[addr[p]];
         end
         chk("rdata", rdata[p], exp_rdata[p]);
         chk("resp", {30'h0, resp[p]}, 32'h0);
         last_grant = p;
         if (drop) req[p] = 1'b0;
      end
   endtask

   task automatic single(input int p, input logic w, input logic [1:0] a,
                         input logic [31:0] d, input logic [3:0] s);
      int got;
      set_req(p, w, a, d, s);
      serve(p, 1'b1, got);
   endtask

   initial begin
      int got, t_ar, t_ack, b_aw, b_w, b_ack, e, nreq;
      logic [31:0] rv;
      for (int p = 0; p < 2; p++) begin
         req[p] = 1'b0; we[p] = 1'b0; addr[p] = 2'h0; wdata[p] = 32'h0; wstrb[p] = 4'h0;
      end
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valids", {27'h0, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 32'h0);
      chk("rst_ack", {30'h0, ack[0], ack[1]}, 32'h0);
      chk("rst_rdata0", rdata[0], 32'h0);
      chk("rst_resp1", {30'h0, resp[1]}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // T1: reset mid-write aborts without ack
      aw_delay = 6; w_delay = 6;
      set_req(0, 1'b1, 2'h1, 32'h12345678, 4'hF);
      repeat (2) @(negedge clk);
      chk("t1_midwrite", {31'h0, bus.awvalid}, 32'h1);
      rst_n = 1'b0; req[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t1_valids", {29'h0, bus.awvalid, bus.wvalid, bus.arvalid}, 32'h0);
         chk("t1_noack", {30'h0, ack[0], ack[1]}, 32'h0);
      end
      rst_n = 1'b1;
      model_reset();
      chk("t1_rdata0", rdata[0], 32'h0);
      aw_delay = 0; w_delay = 0;
      single(1, 1'b0, 2'h1, 32'h0, 4'h0);

      // T2: write then read back
      single(0, 1'b1, 2'h2, 32'hDEADBEEF, 4'hF);
      single(0, 1'b0, 2'h2, 32'h0, 4'h0);
      chk("t2_rdata", rdata[0], 32'hDEADBEEF);

      // T3: simultaneous requests after reset, then alternation while both held
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      set_req(0, 1'b1, 2'h1, 32'h00000011, 4'hF);
      set_req(1, 1'b0, 2'h1, 32'h0, 4'h0);
      for (int k = 0; k < 6; k++) begin
         e = 1 - last_grant;
         serve(e, 1'b0, got);
         if (k == 0) chk("t3_first", got, 0);
         if (k == 1) chk("t3_r1_rdata", rdata[1], 32'h00000011);
      end
      req[0] = 1'b0; req[1] = 1'b0;

      // T4: AW accepted well before W, single bvalid pulse
      aw_delay = 0; w_delay = 3;
      b_aw = n_aw_hs; b_w = n_w_hs; b_ack = n_ack0;
      single(0, 1'b1, 2'h0, 32'hCAFE0001, 4'hF);
      repeat (3) @(negedge clk);
      chk("t4_aw_hs", n_aw_hs - b_aw, 1);
      chk("t4_w_hs", n_w_hs - b_w, 1);
      chk("t4_acks", n_ack0 - b_ack, 1);
      w_delay = 0;

      // T5: read response never arrives
      r_never = 1'b1;
      set_req(1, 1'b0, 2'h1, 32'h0, 4'h0);
      t_ar = -1; t_ack = -1;
      for (int i = 0; i < 100 && t_ack < 0; i++) begin
         @(negedge clk);
         if (bus.arvalid && t_ar < 0) t_ar = i;
         if (ack[1]) t_ack = i;
      end
      chk("t5_latency", t_ack - t_ar, TO);
      chk("t5_resp", {30'h0, resp[1]}, 32'h2);
      chk("t5_rdata", rdata[1], 32'h0);
      chk("t5_rready", {30'h0, bus.rready, bus.arvalid}, 32'h0);
      req[1] = 1'b0; exp_rdata[1] = 32'h0; last_grant = 1;
      r_never = 1'b0;
      @(negedge clk);

      // T6: byte-strobed write over zero
      single(0, 1'b1, 2'h3, 32'h0, 4'hF);
      single(0, 1'b1, 2'h3, 32'hAABBCCDD, 4'b0100);
      single(1, 1'b0, 2'h3, 32'h0, 4'h0);
      chk("t6_rdata", rdata[1], 32'h00BB0000);

      // Randomized traffic: one or both ports, random payloads and slave delays
      for (int it = 0; it < 30; it++) begin
         aw_delay = $urandom_range(0, 3);
         w_delay  = $urandom_range(0, 3);
         nreq = $urandom_range(1, 3);
         for (int p = 0; p < 2; p++)
            if ((nreq >> p) & 1) begin
               rv = $urandom;
               set_req(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rv, 4'($urandom_range(0, 15)));
            end
         if (nreq == 3) begin
            e = 1 - last_grant;
            serve(e, 1'b1, got);
            if (got >= 0) serve(1 - e, 1'b1, got);
         end else begin
            serve(nreq - 1, 1'b1, got);
         end
         req[0] = 1'b0; req[1] = 1'b0;
      end
      for (int a = 0; a < 4; a++) begin
         single(a % 2, 1'b0, 2'(a), 32'h0, 4'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
